// File: rtl/kernel_c_in_fifo_pkg.sv
// Shared types and constants for the kernel_C input FIFO slice.
package kernel_c_in_fifo_pkg;

    localparam int KC_STREAM_W      = 32;
    localparam int KC_DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic                   valid;
        logic [KC_STREAM_W-1:0] data;
    } kc_hs_t;

    // Ceiling log2, usable in parameter defaults.
    function automatic int kc_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kernel_c_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read (MLAB/LUTRAM style).
module kernel_c_fifo_ram
    import kernel_c_in_fifo_pkg::*;
#(
    parameter int WIDTH = KC_STREAM_W,
    parameter int DEPTH = KC_DEFAULT_DEPTH,
    parameter int AW    = kc_log2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset on storage so the array maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kernel_c_in_fifo.sv
// First-word-fall-through elastic buffer in front of kernel_C.
// Optional occupancy/peak outputs are enabled by defining KC_IN_FIFO_STATS_EN.
module kernel_c_in_fifo
    import kernel_c_in_fifo_pkg::*;
#(
    parameter int STREAMW = KC_STREAM_W,
    parameter int DEPTH   = KC_DEFAULT_DEPTH,
    parameter int ADDRW   = kc_log2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid,
    output logic               iready,
    input  logic [STREAMW-1:0] in_s0,
    output logic               ovalid,
    input  logic               oready,
    output logic [STREAMW-1:0] out_s0
`ifdef KC_IN_FIFO_STATS_EN
    ,
    output logic [ADDRW:0]     occupancy,
    output logic [ADDRW:0]     peak
`endif
);

    localparam logic [ADDRW:0]   CNT_FULL = (ADDRW+1)'(DEPTH);
    localparam logic [ADDRW:0]   CNT_ONE  = (ADDRW+1)'(1);
    localparam logic [ADDRW-1:0] PTR_ONE  = ADDRW'(1);

    logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRW:0]   count_q, count_d;
    logic             iready_q, iready_d;
    logic             do_wr, do_rd;

    assign do_wr = ivalid & iready_q;
    assign do_rd = ovalid & oready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Registered so iready never depends combinationally on oready.
        iready_d = (count_d != CNT_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            iready_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            iready_q <= iready_d;
        end
    end

    assign iready = iready_q;
    assign ovalid = (count_q != '0);

    kernel_c_fifo_ram #(
        .WIDTH (STREAMW),
        .DEPTH (DEPTH),
        .AW    (ADDRW)
    ) u_ram (
        .clk     (clk),
        .we_i    (do_wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_s0),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_s0)
    );

`ifdef KC_IN_FIFO_STATS_EN
    logic [ADDRW:0] peak_q;

    // Count never exceeds DEPTH, so the high-water mark saturates there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  peak_q <= '0;
        else if (count_q > peak_q) peak_q <= count_q;
    end

    assign occupancy = count_q;
    assign peak      = peak_q;
`else
    // Statistics disabled: no occupancy or high-water tracking.
`endif

endmodule

// File: tb/tb_kernel_c_in_fifo.sv
// Self-checking bench for kernel_c_in_fifo: vector table, corner sequences, random scoreboard.
module tb_kernel_c_in_fifo;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ivalid = 1'b0;
    logic          iready;
    logic [W-1:0]  in_s0 = '0;
    logic          ovalid;
    logic          oready = 1'b0;
    logic [W-1:0]  out_s0;
`ifdef KC_IN_FIFO_STATS_EN
    logic [AW:0]   occupancy;
    logic [AW:0]   peak;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kernel_c_in_fifo #(.STREAMW(W), .DEPTH(D), .ADDRW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ivalid (ivalid),
        .iready (iready),
        .in_s0  (in_s0),
        .ovalid (ovalid),
        .oready (oready),
        .out_s0 (out_s0)
`ifdef KC_IN_FIFO_STATS_EN
        ,
        .occupancy (occupancy),
        .peak      (peak)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic orr);
        ivalid = iv;
        in_s0  = d;
        oready = orr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_iready", 32'(iready), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_iready", 32'(iready), 32'd1);
        chk("post_rst_ovalid", 32'(ovalid), 32'd0);
    endtask

    typedef struct {
        logic         iv;
        logic         orr;
        logic [W-1:0] din;
        logic         exp_ovalid;
        logic         exp_iready;
        logic [W-1:0] exp_out;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W-1:0] drain_exp[16];
        int q[$];
        int sent, cyc, pre_size, m_peak;
        logic m_ird, iv, orr, acc, rd;
        logic [W-1:0] d;

        // Single word, empty-ignores-oready, read+write at count 1, drain.
        vecs[0] = '{1'b1, 1'b0, 32'h0000_00A5, 1'b1, 1'b1, 32'h0000_00A5};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0033, 1'b1, 1'b1, 32'h0000_0033};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0044, 1'b1, 1'b1, 32'h0000_0044};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0055, 1'b1, 1'b1, 32'h0000_0044};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0055};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].iv, vecs[i].din, vecs[i].orr);
            step();
            chk($sformatf("vec%0d_ovalid", i), 32'(ovalid), 32'(vecs[i].exp_ovalid));
            chk($sformatf("vec%0d_iready", i), 32'(iready), 32'(vecs[i].exp_iready));
            if (vecs[i].exp_ovalid) chk($sformatf("vec%0d_out", i), out_s0, vecs[i].exp_out);
        end

        // Fill to full with back-pressure.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, W'(i), 1'b0);
            step();
            chk($sformatf("fill%0d_iready", i), 32'(iready), (i < 16) ? 32'd1 : 32'd0);
            chk("fill_head", out_s0, 32'h1);
        end
        drive(1'b1, 32'h11, 1'b0);
        repeat (2) begin
            step();
            chk("full_hold_iready", 32'(iready), 32'd0);
            chk("full_hold_head", out_s0, 32'h1);
        end

        // At full, one read frees a slot; 0x11 is taken the following cycle.
        drive(1'b1, 32'h11, 1'b1);
        step();
        chk("full_rd_iready", 32'(iready), 32'd1);
        chk("full_rd_head", out_s0, 32'h2);
        drive(1'b1, 32'h11, 1'b0);
        step();
        chk("refull_iready", 32'(iready), 32'd0);
`ifdef KC_IN_FIFO_STATS_EN
        chk("refull_occ", 32'(occupancy), 32'd16);
`endif

        for (int k = 0; k < 15; k++) drain_exp[k] = W'(k + 2);
        drain_exp[15] = 32'h11;
        drive(1'b0, '0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d_ovalid", k), 32'(ovalid), 32'd1);
            chk($sformatf("drain%0d_out", k), out_s0, drain_exp[k]);
            step();
        end
        chk("drain_empty", 32'(ovalid), 32'd0);

        // Streaming with both sides always ready: 40 words, pointers wrap twice.
        for (int i = 0; i <= 40; i++) begin
            drive(i < 40, W'(32'h100 + i), 1'b1);
            step();
            if (i < 40) begin
                chk($sformatf("tput%0d_ovalid", i), 32'(ovalid), 32'd1);
                chk($sformatf("tput%0d_out", i), out_s0, W'(32'h100 + i));
                chk("tput_iready", 32'(iready), 32'd1);
            end else begin
                chk("tput_end_ovalid", 32'(ovalid), 32'd0);
            end
        end

        // Asynchronous reset mid-cycle with words buffered.
        drive(1'b1, 32'hDEAD_0001, 1'b0);
        step();
        drive(1'b1, 32'hDEAD_0002, 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        chk("pre_arst_ovalid", 32'(ovalid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ovalid", 32'(ovalid), 32'd0);
        chk("arst_iready", 32'(iready), 32'd0);
        do_reset();
        chk("arst_cleared", 32'(ovalid), 32'd0);

        // Random traffic against a queue model.
        m_ird  = 1'b1;
        m_peak = 0;
        sent   = 0;
        cyc    = 0;
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            iv  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            orr = 1'($urandom_range(0, 1));
            d   = $urandom;
            drive(iv, d, orr);
            acc = iv && m_ird;
            rd  = orr && (q.size() > 0);
            pre_size = q.size();
            step();
            if (rd) void'(q.pop_front());
            if (acc) begin
                q.push_back(int'(d));
                sent++;
            end
            m_ird = (q.size() != D);
            if (pre_size > m_peak) m_peak = pre_size;
            chk("rnd_ovalid", 32'(ovalid), 32'(q.size() != 0));
            chk("rnd_iready", 32'(iready), 32'(m_ird));
            if (q.size() != 0) chk("rnd_out", out_s0, 32'(q[0]));
`ifdef KC_IN_FIFO_STATS_EN
            chk("rnd_occ", 32'(occupancy), 32'(q.size()));
            chk("rnd_peak", 32'(peak), 32'(m_peak));
`endif
            cyc++;
        end
        chk("rnd_no_timeout", 32'(cyc < 20000), 32'd1);
        chk("rnd_all_sent", 32'(sent), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
